// File: rtl/cache_pkg.sv
// Shared constants and types for the 2-way write-back cache controller:
// address field geometry, FSM state encoding and a byte-lane helper.
package cache_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int SETS      = 2;
    localparam int BLK_WORDS = 4;
    localparam int CNT_W     = 16;

    localparam int LANES  = DATA_W / 8;
    localparam int WORD_W = $clog2(BLK_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    // Field positions within a byte address: {tag, index, word, byte}
    localparam int WORD_LSB = 2;
    localparam int IDX_LSB  = OFF_W;
    localparam int TAG_LSB  = OFF_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    function automatic logic [LANES-1:0] byte_en(input logic [1:0] lane);
        logic [LANES-1:0] be;
        be       = '0;
        be[lane] = 1'b1;
        return be;
    endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Data array for both ways: per-byte write enable on one write port and two
// combinational read ports (CPU word and write-back beat).
module cache_data_ram
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              way_w,
    input  logic [IDX_W-1:0]  set_w,
    input  logic [WORD_W-1:0] word_w,
    input  logic [LANES-1:0]  be,
    input  logic [DATA_W-1:0] wdata,
    input  logic              way_a,
    input  logic [IDX_W-1:0]  set_a,
    input  logic [WORD_W-1:0] word_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              way_b,
    input  logic [IDX_W-1:0]  set_b,
    input  logic [WORD_W-1:0] word_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [2][SETS][BLK_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (we && be[b]) begin
                mem[way_w][set_w][word_w][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata_a = mem[way_a][set_a][word_a];
    assign rdata_b = mem[way_b][set_b][word_b];

endmodule

// File: rtl/cache_ctrl_2way_wb.sv
// 2-way set-associative write-back LRU cache controller: hit compare, dirty
// victim write-back and 4-beat refill. Define CACHE_STATS_EN for hit/miss/wb counters.
module cache_ctrl_2way_wb
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              hit_miss,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt,
`endif
    input  logic              mem_ack
);

    state_t              state;
    logic                req_rw;
    logic [ADDR_W-1:0]   req_addr;
    logic [7:0]          req_wdata;
    logic [TAG_W-1:0]    tag   [SETS][2];
    logic [1:0]          valid [SETS];
    logic [1:0]          dirty [SETS];
    logic [SETS-1:0]     lru;
    logic [WORD_W-1:0]   cnt;
    logic                victim;
    logic                miss_flag;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WORD_W-1:0]   req_word;
    logic                hit0, hit1, hit, hit_way;
    logic                victim_sel, victim_dirty, last_beat;

    logic                ram_we, ram_way;
    logic [WORD_W-1:0]   ram_word;
    logic [LANES-1:0]    ram_be;
    logic [DATA_W-1:0]   ram_wdata, rdata_a, rdata_b;

    assign req_tag  = req_addr[TAG_LSB +: TAG_W];
    assign req_idx  = req_addr[IDX_LSB +: IDX_W];
    assign req_word = req_addr[WORD_LSB +: WORD_W];

    assign hit0    = valid[req_idx][0] && (tag[req_idx][0] == req_tag);
    assign hit1    = valid[req_idx][1] && (tag[req_idx][1] == req_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;

    // Fill an empty way first (way0 preferred) before evicting the LRU way
    assign victim_sel   = !valid[req_idx][0] ? 1'b0 :
                          !valid[req_idx][1] ? 1'b1 : lru[req_idx];
    assign victim_dirty = valid[req_idx][victim_sel] && dirty[req_idx][victim_sel];
    assign last_beat    = (cnt == WORD_W'(BLK_WORDS - 1));

    always_comb begin
        ram_we    = 1'b0;
        ram_way   = hit_way;
        ram_word  = req_word;
        ram_be    = byte_en(req_addr[1:0]);
        ram_wdata = {LANES{req_wdata}};
        if (state == COMPARE && hit && req_rw) begin
            ram_we = 1'b1;
        end else if (state == ALLOCATE && mem_req && mem_ack) begin
            ram_we    = 1'b1;
            ram_way   = victim;
            ram_word  = cnt;
            ram_be    = '1;
            ram_wdata = mem_rdata;
        end
    end

    // Port b follows the victim that COMPARE is about to latch, so beat 0 data is ready on entry
    cache_data_ram u_ram (
        .clk     (clk),
        .we      (ram_we),
        .way_w   (ram_way),
        .set_w   (req_idx),
        .word_w  (ram_word),
        .be      (ram_be),
        .wdata   (ram_wdata),
        .way_a   (hit_way),
        .set_a   (req_idx),
        .word_a  (req_word),
        .rdata_a (rdata_a),
        .way_b   ((state == COMPARE) ? victim_sel : victim),
        .set_b   (req_idx),
        .word_b  (cnt),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            lru       <= '0;
            cnt       <= '0;
            victim    <= 1'b0;
            miss_flag <= 1'b0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            hit_miss  <= 1'b0;
            mem_req   <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s]  <= '0;
                dirty[s]  <= '0;
                tag[s][0] <= '0;
                tag[s][1] <= '0;
            end
        end else begin
            cpu_ready <= 1'b0;
            hit_miss  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_rw    <= cpu_rw;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        cpu_ready    <= 1'b1;
                        hit_miss     <= !miss_flag;
                        cpu_rdata    <= rdata_a;
                        lru[req_idx] <= !hit_way;
                        if (req_rw) begin
                            dirty[req_idx][hit_way] <= 1'b1;
                        end
                        miss_flag <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        miss_flag <= 1'b1;
                        victim    <= victim_sel;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        if (victim_dirty) begin
                            mem_rw    <= 1'b1;
                            mem_addr  <= {tag[req_idx][victim_sel], req_idx, WORD_W'(0), 2'b00};
                            mem_wdata <= rdata_b;
                            state     <= WRITEBACK;
                        end else begin
                            mem_rw   <= 1'b0;
                            mem_addr <= {req_tag, req_idx, WORD_W'(0), 2'b00};
                            state    <= ALLOCATE;
                        end
                    end
                end
                // A low mem_req here is the one idle cycle after an ack; re-raise for the next beat
                WRITEBACK: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_rw    <= 1'b1;
                        mem_addr  <= {tag[req_idx][victim], req_idx, cnt, 2'b00};
                        mem_wdata <= rdata_b;
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        if (last_beat) begin
                            dirty[req_idx][victim] <= 1'b0;
                            mem_rw                 <= 1'b0;
                            state                  <= ALLOCATE;
                        end
                    end
                end
                ALLOCATE: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_rw   <= 1'b0;
                        mem_addr <= {req_tag, req_idx, cnt, 2'b00};
                    end else if (mem_ack) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        if (last_beat) begin
                            valid[req_idx][victim] <= 1'b1;
                            dirty[req_idx][victim] <= 1'b0;
                            tag[req_idx][victim]   <= req_tag;
                            state                  <= COMPARE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (cpu_ready && hit_miss && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (cpu_ready && !hit_miss && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (state == COMPARE && !hit && victim_dirty && wb_cnt != '1) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
